// File: rtl/fastica_pkg.sv
// Shared FastICA datapath definitions: element format, saturation bounds and
// the mean-accumulator FSM state encoding.
package fastica_pkg;

    localparam int unsigned W = 26;

    typedef logic signed [W-1:0] elem_t;

    localparam elem_t SAT_MAX = elem_t'((1 << (W - 1)) - 1);
    localparam elem_t SAT_MIN = elem_t'(-(1 << (W - 1)));

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } state_e;

endpackage

// File: rtl/mean_acc_lane.sv
// One matrix element: running sum of products, floor mean by arithmetic shift,
// and the saturated 3w term from the weight latched at start.
module mean_acc_lane #(
    parameter int unsigned W      = 26,
    parameter int unsigned LOG2_N = 8
) (
    input  logic                clk_acc,
    input  logic                rstn_acc,
    input  logic                clr,
    input  logic                add,
    input  logic                emit,
    input  logic signed [W-1:0] w,
    input  logic signed [W-1:0] p,
    output logic signed [W-1:0] m,
    output logic signed [W-1:0] t
);

    localparam int unsigned AW = W + LOG2_N;
    localparam logic signed [W+1:0] TMax = {3'b000, {(W - 1){1'b1}}};
    localparam logic signed [W+1:0] TMin = {3'b111, {(W - 1){1'b0}}};

    logic signed [AW-1:0] acc_q;
    logic signed [W-1:0]  w_q;
    logic signed [W+1:0]  t3;
    logic signed [W-1:0]  t_sat;

    always_comb begin
        t3 = ({{2{w_q[W-1]}}, w_q} <<< 1) + {{2{w_q[W-1]}}, w_q};
        if (t3 > TMax) begin
            t_sat = TMax[W-1:0];
        end else if (t3 < TMin) begin
            t_sat = TMin[W-1:0];
        end else begin
            t_sat = t3[W-1:0];
        end
    end

    always_ff @(posedge clk_acc) begin
        if (!rstn_acc) begin
            acc_q <= '0;
            w_q   <= '0;
            m     <= '0;
            t     <= '0;
        end else begin
            if (clr) begin
                acc_q <= '0;
                w_q   <= w;
            end else if (add) begin
                acc_q <= acc_q + {{LOG2_N{p[W-1]}}, p};
            end
            // Dropping the low LOG2_N bits is the floor-rounding arithmetic shift.
            if (emit) begin
                m <= acc_q[AW-1:LOG2_N];
                t <= t_sat;
            end
        end
    end

endmodule

// File: rtl/one_unit_mean_acc.sv
// Accumulates N = 2^LOG2_N 4x4 product matrices, then presents the mean and 3w
// matrices to the one-unit subtractor with a single-cycle enable pulse.
module one_unit_mean_acc #(
    parameter int unsigned W      = 26,
    parameter int unsigned LOG2_N = 8
) (
    input  logic                clk_acc,
    input  logic                rstn_acc,
    input  logic                start_acc,
    input  logic signed [W-1:0] w_11, w_12, w_13, w_14, w_21, w_22, w_23, w_24,
    input  logic signed [W-1:0] w_31, w_32, w_33, w_34, w_41, w_42, w_43, w_44,
    input  logic                valid_acc,
    input  logic signed [W-1:0] p_11, p_12, p_13, p_14, p_21, p_22, p_23, p_24,
    input  logic signed [W-1:0] p_31, p_32, p_33, p_34, p_41, p_42, p_43, p_44,
    output logic signed [W-1:0] m_11, m_12, m_13, m_14, m_21, m_22, m_23, m_24,
    output logic signed [W-1:0] m_31, m_32, m_33, m_34, m_41, m_42, m_43, m_44,
    output logic signed [W-1:0] t_11, t_12, t_13, t_14, t_21, t_22, t_23, t_24,
    output logic signed [W-1:0] t_31, t_32, t_33, t_34, t_41, t_42, t_43, t_44,
    output logic                en_sub,
    output logic                busy_acc,
    output logic [LOG2_N:0]     cnt_acc
);

    import fastica_pkg::*;

    localparam logic [LOG2_N:0] NCnt = {1'b1, {LOG2_N{1'b0}}};

    state_e          state_q;
    logic [LOG2_N:0] cnt_q;
    logic            lane_clr;
    logic            lane_add;
    logic            lane_emit;
    logic [16*W-1:0] w_flat;
    logic [16*W-1:0] p_flat;
    logic [16*W-1:0] m_flat;
    logic [16*W-1:0] t_flat;

    assign w_flat = {w_44, w_43, w_42, w_41, w_34, w_33, w_32, w_31,
                     w_24, w_23, w_22, w_21, w_14, w_13, w_12, w_11};
    assign p_flat = {p_44, p_43, p_42, p_41, p_34, p_33, p_32, p_31,
                     p_24, p_23, p_22, p_21, p_14, p_13, p_12, p_11};
    assign {m_44, m_43, m_42, m_41, m_34, m_33, m_32, m_31,
            m_24, m_23, m_22, m_21, m_14, m_13, m_12, m_11} = m_flat;
    assign {t_44, t_43, t_42, t_41, t_34, t_33, t_32, t_31,
            t_24, t_23, t_22, t_21, t_14, t_13, t_12, t_11} = t_flat;

    // The cycle after the Nth sample is spent in ACC with a full count; the
    // results are registered on its closing edge, which is the edge entering OUT.
    assign lane_clr  = (state_q == IDLE) && start_acc;
    assign lane_add  = (state_q == ACC) && (cnt_q != NCnt) && valid_acc;
    assign lane_emit = (state_q == ACC) && (cnt_q == NCnt);
    assign cnt_acc   = cnt_q;

    always_ff @(posedge clk_acc) begin
        if (!rstn_acc) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            en_sub   <= 1'b0;
            busy_acc <= 1'b0;
        end else begin
            en_sub <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (lane_clr) begin
                        state_q  <= ACC;
                        cnt_q    <= '0;
                        busy_acc <= 1'b1;
                    end
                end
                ACC: begin
                    if (lane_emit) begin
                        state_q <= OUT;
                        en_sub  <= 1'b1;
                    end else if (lane_add) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                OUT: begin
                    state_q  <= IDLE;
                    busy_acc <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_lane
        mean_acc_lane #(
            .W      (W),
            .LOG2_N (LOG2_N)
        ) u_lane (
            .clk_acc  (clk_acc),
            .rstn_acc (rstn_acc),
            .clr      (lane_clr),
            .add      (lane_add),
            .emit     (lane_emit),
            .w        (w_flat[i*W +: W]),
            .p        (p_flat[i*W +: W]),
            .m        (m_flat[i*W +: W]),
            .t        (t_flat[i*W +: W])
        );
    end

endmodule

// File: tb/tb_one_unit_mean_acc.sv
// Randomized bench for one_unit_mean_acc against a plain-arithmetic mean/3w model.
module tb_one_unit_mean_acc;

    localparam int unsigned W      = 26;
    localparam int unsigned LOG2_N = 2;
    localparam int unsigned N      = 1 << LOG2_N;

    logic                clk = 1'b0;
    logic                rstn;
    logic                start;
    logic                valid;
    logic signed [W-1:0] w [16];
    logic signed [W-1:0] p [16];
    logic signed [W-1:0] m [16];
    logic signed [W-1:0] t [16];
    logic                en_sub;
    logic                busy;
    logic [LOG2_N:0]     cnt;

    int n_total   = 0;
    int n_bad     = 0;
    int n_pulse   = 0;
    int exp_pulse = 0;

    logic signed [W-1:0] wv [16];
    logic signed [W-1:0] samp [N][16];
    longint              exp_m [16];
    longint              exp_t [16];

    always #5 clk = ~clk;

    always @(negedge clk) if (en_sub) n_pulse++;

    one_unit_mean_acc #(.W(W), .LOG2_N(LOG2_N)) dut (
        .clk_acc(clk), .rstn_acc(rstn), .start_acc(start), .valid_acc(valid),
        .w_11(w[0]),  .w_12(w[1]),  .w_13(w[2]),  .w_14(w[3]),
        .w_21(w[4]),  .w_22(w[5]),  .w_23(w[6]),  .w_24(w[7]),
        .w_31(w[8]),  .w_32(w[9]),  .w_33(w[10]), .w_34(w[11]),
        .w_41(w[12]), .w_42(w[13]), .w_43(w[14]), .w_44(w[15]),
        .p_11(p[0]),  .p_12(p[1]),  .p_13(p[2]),  .p_14(p[3]),
        .p_21(p[4]),  .p_22(p[5]),  .p_23(p[6]),  .p_24(p[7]),
        .p_31(p[8]),  .p_32(p[9]),  .p_33(p[10]), .p_34(p[11]),
        .p_41(p[12]), .p_42(p[13]), .p_43(p[14]), .p_44(p[15]),
        .m_11(m[0]),  .m_12(m[1]),  .m_13(m[2]),  .m_14(m[3]),
        .m_21(m[4]),  .m_22(m[5]),  .m_23(m[6]),  .m_24(m[7]),
        .m_31(m[8]),  .m_32(m[9]),  .m_33(m[10]), .m_34(m[11]),
        .m_41(m[12]), .m_42(m[13]), .m_43(m[14]), .m_44(m[15]),
        .t_11(t[0]),  .t_12(t[1]),  .t_13(t[2]),  .t_14(t[3]),
        .t_21(t[4]),  .t_22(t[5]),  .t_23(t[6]),  .t_24(t[7]),
        .t_31(t[8]),  .t_32(t[9]),  .t_33(t[10]), .t_34(t[11]),
        .t_41(t[12]), .t_42(t[13]), .t_43(t[14]), .t_44(t[15]),
        .en_sub(en_sub), .busy_acc(busy), .cnt_acc(cnt)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [W-1:0] rand_elem();
        logic [31:0] r = $urandom();
        return r[W-1:0];
    endfunction

    function automatic longint floor_div(input longint s);
        longint nl = longint'(N);
        longint r  = s % nl;
        if (r < 0) r += nl;
        return (s - r) / nl;
    endfunction

    task automatic compute_expect();
        longint sum;
        longint t3;
        longint hi = longint'(fastica_pkg::SAT_MAX);
        longint lo = longint'(fastica_pkg::SAT_MIN);
        for (int e = 0; e < 16; e++) begin
            sum = 0;
            for (int s = 0; s < N; s++) sum += samp[s][e];
            exp_m[e] = floor_div(sum);
            t3 = 3 * longint'(wv[e]);
            exp_t[e] = (t3 > hi) ? hi : ((t3 < lo) ? lo : t3);
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int e = 0; e < 16; e++) begin
            check($sformatf("%s_m[%0d]", tag, e), m[e], exp_m[e]);
            check($sformatf("%s_t[%0d]", tag, e), t[e], exp_t[e]);
        end
    endtask

    task automatic fill_random();
        for (int e = 0; e < 16; e++) begin
            wv[e] = rand_elem();
            for (int s = 0; s < N; s++) samp[s][e] = rand_elem();
        end
    endtask

    task automatic run_iter(input bit gaps, input bit start_with_valid);
        for (int e = 0; e < 16; e++) begin
            w[e] = wv[e];
            p[e] = rand_elem();
        end
        start = 1'b1;
        valid = start_with_valid;
        step();
        start = 1'b0;
        for (int e = 0; e < 16; e++) w[e] = rand_elem();
        check("cnt_after_start", cnt, 0);
        check("busy_in_acc", busy, 1);
        for (int s = 0; s < N; s++) begin
            if (gaps) begin
                repeat ($urandom_range(1, 3)) begin
                    valid = 1'b0;
                    start = 1'($urandom_range(0, 1));
                    for (int e = 0; e < 16; e++) p[e] = rand_elem();
                    step();
                    check("cnt_stall", cnt, s);
                end
                start = 1'b0;
            end
            valid = 1'b1;
            for (int e = 0; e < 16; e++) p[e] = samp[s][e];
            step();
            check("cnt_accept", cnt, s + 1);
            check("en_sub_early", en_sub, 0);
        end
        // Full-count cycle and OUT cycle must ignore both valid and start.
        valid = 1'b1;
        start = 1'b1;
        for (int e = 0; e < 16; e++) p[e] = rand_elem();
        step();
        compute_expect();
        exp_pulse++;
        check("en_sub_out", en_sub, 1);
        check("busy_out", busy, 1);
        check("cnt_out", cnt, N);
        check_outputs("out");
        step();
        valid = 1'b0;
        start = 1'b0;
        check("en_sub_after", en_sub, 0);
        check("busy_idle", busy, 0);
        check("cnt_idle", cnt, N);
        check_outputs("hold");
        step();
        check("en_sub_idle", en_sub, 0);
        check_outputs("hold2");
    endtask

    initial begin
        rstn  = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        for (int e = 0; e < 16; e++) begin
            w[e]     = rand_elem();
            p[e]     = rand_elem();
            exp_m[e] = 0;
            exp_t[e] = 0;
        end
        repeat (2) step();
        check("rst_en_sub", en_sub, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", cnt, 0);
        check_outputs("rst");
        rstn = 1'b1;
        step();

        // All w = 1, all p = 4.
        for (int e = 0; e < 16; e++) begin
            wv[e] = 1;
            for (int s = 0; s < N; s++) samp[s][e] = 4;
        end
        run_iter(1'b0, 1'b0);
        check("const_m11", m[0], 4);
        check("const_t22", t[5], 3);

        // Floor rounding and 3w saturation; start arrives with valid high.
        fill_random();
        wv[0] = fastica_pkg::SAT_MAX;
        wv[1] = fastica_pkg::SAT_MIN;
        wv[2] = -5;
        for (int s = 0; s < N; s++) begin
            samp[s][0] = (s < 3) ? -1 : 0;
            samp[s][5] = (s < 3) ? 1 : 0;
        end
        run_iter(1'b0, 1'b1);
        check("floor_m11", m[0], -1);
        check("floor_m22", m[5], 0);
        check("sat_t11", t[0], longint'(fastica_pkg::SAT_MAX));
        check("sat_t12", t[1], longint'(fastica_pkg::SAT_MIN));
        check("neg_t13", t[2], -15);

        // Same data with and without stalls and stray starts.
        fill_random();
        run_iter(1'b0, 1'b0);
        run_iter(1'b1, 1'b0);

        // Reset after two samples: no pulse, everything back to zero.
        fill_random();
        for (int e = 0; e < 16; e++) w[e] = wv[e];
        start = 1'b1;
        step();
        start = 1'b0;
        for (int s = 0; s < 2; s++) begin
            valid = 1'b1;
            for (int e = 0; e < 16; e++) p[e] = samp[s][e];
            step();
        end
        rstn = 1'b0;
        step();
        for (int e = 0; e < 16; e++) begin
            exp_m[e] = 0;
            exp_t[e] = 0;
        end
        check("mid_rst_en_sub", en_sub, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cnt", cnt, 0);
        check_outputs("mid_rst");
        rstn  = 1'b1;
        valid = 1'b0;
        repeat (3) begin
            step();
            check("post_rst_en_sub", en_sub, 0);
        end
        fill_random();
        run_iter(1'b0, 1'b0);

        // Back-to-back iterations with fresh weights each time.
        for (int k = 0; k < 5; k++) begin
            fill_random();
            run_iter(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        step();
        check("pulse_count", n_pulse, exp_pulse);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/one_unit_mean_acc.md
Name: one_unit_mean_acc

Overview:
- Producer for the one-unit weight-update subtractor in the FastICA datapath.
- Accumulates a stream of 4x4 signed fixed-point product matrices, z*g(w'z), over N = 2^LOG2_N samples.
- Emits the element-wise mean matrix and the 3w matrix, derived from the weight latched at start.
- Pulses the subtractor enable for exactly one cycle when both matrices are valid, so the subtractor registers mean - 3w.

Parameters:
- W, 26: element width, signed two's complement; must match the subtractor inputs.
- LOG2_N, 8: log2 of the sample count per iteration; N = 2^LOG2_N; legal range 1..16.

Ports:
- clk_acc  in  1  clock; all state updates on the rising edge.
- rstn_acc  in  1  reset, synchronous, active-low.
- start_acc  in  1  one-cycle pulse that begins an iteration; honoured only in IDLE.
- w_11..w_44  in  16 x W signed  current weight matrix; sampled only on an accepted start.
- valid_acc  in  1  p_* carries a sample this cycle; honoured only in ACC.
- p_11..p_44  in  16 x W signed  product matrix for one sample.
- m_11..m_44  out  16 x W signed  registered mean matrix; drives the subtractor's mean inputs.
- t_11..t_44  out  16 x W signed  registered 3w matrix; drives the subtractor's 3w inputs.
- en_sub  out  1  one-cycle pulse; drives the subtractor enable.
- busy_acc  out  1  high in ACC and OUT.
- cnt_acc  out  LOG2_N+1  number of samples accepted in the current iteration.

Behaviour:
- Reset (rstn_acc low at a clock edge):
  - All outputs go to 0: m_*, t_*, en_sub, busy_acc, cnt_acc.
  - Accumulators and the latched weight clear; state goes to IDLE.
  - Reset takes priority over every other input, including in the middle of ACC or OUT; no partial result is emitted.
- States:
  - IDLE -> ACC on start_acc.
    - Clears the accumulators and cnt_acc.
    - Latches w_* into internal registers.
    - valid_acc asserted in the same cycle as the start is ignored.
  - ACC, each cycle valid_acc = 1:
    - acc_ij += sign-extended p_ij for all 16 elements in parallel; cnt_acc += 1.
    - When the accepted sample makes cnt_acc = N, go to OUT next cycle.
    - valid_acc = 0 stalls; there is no timeout.
    - start_acc is ignored.
  - OUT, lasting one cycle:
    - m_* and t_* are updated at the edge entering OUT.
    - en_sub = 1 during the OUT cycle; busy_acc stays 1.
    - Next state is IDLE; valid_acc and start_acc are ignored.
- Latency: the Nth accepted sample at edge k gives m_*, t_* and en_sub valid after edge k+1, for one cycle. Start-to-pulse is at least N+1 cycles.
- Arithmetic:
  - Accumulator width is W+LOG2_N bits; it cannot overflow.
  - m_ij = acc_ij >>> LOG2_N, an arithmetic shift that rounds toward negative infinity. The result always fits in W bits.
  - t_ij = (w_ij <<< 1) + w_ij, computed at W+2 bits, then saturated to [-2^(W-1), 2^(W-1)-1].
- Hold: m_* and t_* keep their values from OUT until the next OUT or reset. With en_sub low the subtractor passes t_* through, and this is the intended behaviour.
- Counter: cnt_acc holds N through OUT and IDLE, and clears on the next accepted start.

Decomposition:
- Shared package fastica_pkg:
  - W = 26.
  - Element type: signed [W-1:0].
  - Saturation constants: SAT_MAX = 2^25-1, SAT_MIN = -2^25.
  - State encoding: IDLE, ACC, OUT.
- One natural sub-module, mean_acc_lane:
  - A single-element accumulator plus shift plus 3x-saturate lane.
  - Instantiated 16 times.
  - The top level holds the FSM and the counter.

Test Plan:
- LOG2_N=2, start with all w=1, then 4 valid samples with all p=4 -> one cycle after the 4th sample, m=4, t=3 and en_sub=1 for exactly 1 cycle; then IDLE with busy_acc=0.
- LOG2_N=2, p_11 sequence -1, -1, -1, 0 -> m_11=-1 (floor of -3/4); p_22 sequence 1, 1, 1, 0 -> m_22=0.
- Saturation on t: w_11=2^25-1 gives t_11=2^25-1; w_12=-2^25 gives t_12=-2^25; w_13=-5 gives t_13=-15.
- Back-pressure and ignored inputs:
  - Insert valid_acc=0 gaps, and assert start_acc mid-ACC -> the count and result are identical to the gap-free run.
  - A start in the same cycle as valid is not counted: cnt_acc reaches 4 only after 4 later valid samples.
- Reset mid-ACC after 2 samples -> all outputs 0 on the next cycle, no en_sub pulse; a fresh iteration afterwards produces the correct mean.
- Back-to-back iterations -> m_* and t_* hold between OUT cycles; a second iteration with new w gives updated t_*, and en_sub pulses exactly once per iteration.
